// File: rtl/riscv_i32_trace_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_i32_trace_buffer_if                                                  |
// | Trace tap, control and read-back bus for riscv_i32_trace_buffer.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface riscv_i32_trace_buffer_if #(
    parameter int DEPTH_LOG2  = 4,
    parameter int COUNT_WIDTH = 16
);
    logic                   trace__instr_valid;
    logic [31:0]            trace__instr_pc;
    logic [2:0]             trace__instruction__mode;
    logic [31:0]            trace__instruction__data;
    logic                   trace__rfw_retire;
    logic                   trace__rfw_data_valid;
    logic [4:0]             trace__rfw_rd;
    logic [31:0]            trace__rfw_data;
    logic                   trace__branch_taken;
    logic [31:0]            trace__branch_target;
    logic                   trace__trap;
    logic                   ctl_enable;
    logic [1:0]             ctl_mode;
    logic                   ctl_clear;
    logic                   rd_req;
    logic                   rd_ack;
    logic [31:0]            rd_pc;
    logic [31:0]            rd_instr;
    logic [4:0]             rd_rd;
    logic [31:0]            rd_data;
    logic [2:0]             rd_flags;
    logic [DEPTH_LOG2:0]    level;
    logic                   overflow;
    logic                   frozen;
    logic [COUNT_WIDTH-1:0] instr_count;

    modport master (
        output trace__instr_valid, trace__instr_pc, trace__instruction__mode,
               trace__instruction__data, trace__rfw_retire, trace__rfw_data_valid,
               trace__rfw_rd, trace__rfw_data, trace__branch_taken,
               trace__branch_target, trace__trap, ctl_enable, ctl_mode,
               ctl_clear, rd_req,
        input  rd_ack, rd_pc, rd_instr, rd_rd, rd_data, rd_flags, level,
               overflow, frozen, instr_count
    );

    modport slave (
        input  trace__instr_valid, trace__instr_pc, trace__instruction__mode,
               trace__instruction__data, trace__rfw_retire, trace__rfw_data_valid,
               trace__rfw_rd, trace__rfw_data, trace__branch_taken,
               trace__branch_target, trace__trap, ctl_enable, ctl_mode,
               ctl_clear, rd_req,
        output rd_ack, rd_pc, rd_instr, rd_rd, rd_data, rd_flags, level,
               overflow, frozen, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/riscv_i32_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_i32_trace_buffer                                                     |
// | Circular capture buffer of retired-instruction trace records.              |
// | Optional: RISCV_I32_TRACE_RFW_DATA_EN stores rfw write data per entry.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_i32_trace_buffer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic              clk,
    input  wire logic              clk__enable,
    input  wire logic              reset_n,
    riscv_i32_trace_buffer_if.slave bus
);
    localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [1:0]          c_MODE_STOP  = 2'd1;
    localparam logic [1:0]          c_MODE_FREEZE = 2'd2;
    localparam logic [1:0]          c_MODE_FILTER = 2'd3;

    logic [31:0]            r_mem_pc    [c_DEPTH];
    logic [31:0]            r_mem_instr [c_DEPTH];
    logic [4:0]             r_mem_rd    [c_DEPTH];
    logic [2:0]             r_mem_flags [c_DEPTH];

    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_level;
    logic                   r_overflow;
    logic                   r_frozen;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_rd_ack;
    logic [31:0]            r_rd_pc;
    logic [31:0]            r_rd_instr;
    logic [4:0]             r_rd_rd;
    logic [31:0]            r_rd_data;
    logic [2:0]             r_rd_flags;

    logic w_full;
    logic w_retire;
    logic w_capture;
    logic w_pop;
    logic w_write;
    logic w_rd_adv;

    always_comb begin
        w_full    = (r_level == c_FULL_LEVEL);
        w_retire  = bus.ctl_enable & bus.trace__instr_valid;
        w_capture = w_retire & ~r_frozen &
                    ((bus.ctl_mode != c_MODE_FILTER) | bus.trace__branch_taken | bus.trace__trap);
        w_pop     = bus.rd_req & (r_level != '0);
        // A full buffer still accepts in stop mode when a pop frees the slot this cycle.
        w_write   = w_capture & (~w_full | w_pop | (bus.ctl_mode != c_MODE_STOP));
        w_rd_adv  = w_pop | (w_write & w_full);
    end

    always_ff @(posedge clk) begin
        if (clk__enable && !bus.ctl_clear && w_write) begin
            r_mem_pc[r_wr_ptr]    <= bus.trace__instr_pc;
            r_mem_instr[r_wr_ptr] <= bus.trace__instruction__data;
            r_mem_rd[r_wr_ptr]    <= bus.trace__rfw_rd;
            r_mem_flags[r_wr_ptr] <= {bus.trace__trap, bus.trace__branch_taken, bus.trace__rfw_retire};
        end
    end

`ifdef RISCV_I32_TRACE_RFW_DATA_EN
    logic [31:0] r_mem_data [c_DEPTH];

    always_ff @(posedge clk) begin
        if (clk__enable && !bus.ctl_clear && w_write) begin
            r_mem_data[r_wr_ptr] <= bus.trace__rfw_data;
        end
    end

    wire w_unused = ^{bus.trace__instruction__mode, bus.trace__rfw_data_valid,
                      bus.trace__branch_target};
`else
    wire w_unused = ^{bus.trace__instruction__mode, bus.trace__rfw_data_valid,
                      bus.trace__branch_target, bus.trace__rfw_data};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_frozen   <= 1'b0;
            r_count    <= '0;
            r_rd_ack   <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_rd    <= '0;
            r_rd_data  <= '0;
            r_rd_flags <= '0;
        end else if (clk__enable) begin
            if (bus.ctl_clear) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_level    <= '0;
                r_overflow <= 1'b0;
                r_frozen   <= 1'b0;
                r_count    <= '0;
                r_rd_ack   <= 1'b0;
            end else begin
                r_rd_ack <= w_pop;
                if (w_pop) begin
                    r_rd_pc    <= r_mem_pc[r_rd_ptr];
                    r_rd_instr <= r_mem_instr[r_rd_ptr];
                    r_rd_rd    <= r_mem_rd[r_rd_ptr];
                    r_rd_flags <= r_mem_flags[r_rd_ptr];
`ifdef RISCV_I32_TRACE_RFW_DATA_EN
                    r_rd_data  <= r_mem_data[r_rd_ptr];
`else
                    r_rd_data  <= '0;
`endif
                end
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_adv) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_write && !w_full && !w_pop) begin
                    r_level <= r_level + 1'b1;
                end else if (w_pop && !w_write) begin
                    r_level <= r_level - 1'b1;
                end
                if (w_capture && w_full && !w_pop) begin
                    r_overflow <= 1'b1;
                end
                if (w_capture && bus.ctl_mode == c_MODE_FREEZE && bus.trace__trap) begin
                    r_frozen <= 1'b1;
                end
                if (w_retire && r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.rd_ack      = r_rd_ack;
    assign bus.rd_pc       = r_rd_pc;
    assign bus.rd_instr    = r_rd_instr;
    assign bus.rd_rd       = r_rd_rd;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_flags    = r_rd_flags;
    assign bus.level       = r_level;
    assign bus.overflow    = r_overflow;
    assign bus.frozen      = r_frozen;
    assign bus.instr_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_riscv_i32_trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_i32_trace_buffer                                                  |
// | Directed scoreboard bench for riscv_i32_trace_buffer.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_riscv_i32_trace_buffer;
    localparam int c_DEPTH_LOG2  = 4;
    localparam int c_COUNT_WIDTH = 16;

    logic clk;
    logic clk__enable;
    logic reset_n;

    riscv_i32_trace_buffer_if #(.DEPTH_LOG2(c_DEPTH_LOG2), .COUNT_WIDTH(c_COUNT_WIDTH)) bus ();

    riscv_i32_trace_buffer #(.DEPTH_LOG2(c_DEPTH_LOG2), .COUNT_WIDTH(c_COUNT_WIDTH)) dut (
        .clk         (clk),
        .clk__enable (clk__enable),
        .reset_n     (reset_n),
        .bus         (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  flags;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h1357_0013;
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] pc);
`ifdef RISCV_I32_TRACE_RFW_DATA_EN
        return ~pc;
`else
        return 32'h0 & pc;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack consumes one expected record
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.rd_ack) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got pc 0x%0h expected no ack", bus.rd_pc);
            end else begin
                e = q.pop_front();
                chk("rd_pc",    64'(bus.rd_pc),    64'(e.pc));
                chk("rd_instr", 64'(bus.rd_instr), 64'(instr_of(e.pc)));
                chk("rd_rd",    64'(bus.rd_rd),    64'(e.pc[6:2]));
                chk("rd_data",  64'(bus.rd_data),  64'(data_of(e.pc)));
                chk("rd_flags", 64'(bus.rd_flags), 64'(e.flags));
            end
        end
    end

    task automatic retire(input logic [31:0] pc, input logic br, input logic tr);
        bus.trace__instr_valid       = 1'b1;
        bus.trace__instr_pc          = pc;
        bus.trace__instruction__mode = pc[2:0];
        bus.trace__instruction__data = instr_of(pc);
        bus.trace__rfw_retire        = 1'b1;
        bus.trace__rfw_data_valid    = 1'b1;
        bus.trace__rfw_rd            = pc[6:2];
        bus.trace__rfw_data          = ~pc;
        bus.trace__branch_taken      = br;
        bus.trace__branch_target     = pc + 32'd8;
        bus.trace__trap              = tr;
        @(negedge clk);
        bus.trace__instr_valid  = 1'b0;
        bus.trace__branch_taken = 1'b0;
        bus.trace__trap         = 1'b0;
    endtask

    task automatic pop(input logic [31:0] pc, input logic [2:0] flags);
        exp_t e;
        e.pc = pc;
        e.flags = flags;
        q.push_back(e);
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
    endtask

    task automatic clear();
        bus.ctl_clear = 1'b1;
        @(negedge clk);
        bus.ctl_clear = 1'b0;
    endtask

    initial begin
        exp_t e;
        reset_n     = 1'b0;
        clk__enable = 1'b1;
        bus.trace__instr_valid = 1'b0;  bus.trace__instr_pc = '0;
        bus.trace__instruction__mode = '0; bus.trace__instruction__data = '0;
        bus.trace__rfw_retire = 1'b0;   bus.trace__rfw_data_valid = 1'b0;
        bus.trace__rfw_rd = '0;         bus.trace__rfw_data = '0;
        bus.trace__branch_taken = 1'b0; bus.trace__branch_target = '0;
        bus.trace__trap = 1'b0;
        bus.ctl_enable = 1'b1; bus.ctl_mode = 2'd0; bus.ctl_clear = 1'b0; bus.rd_req = 1'b0;
        #1;
        chk("reset_level",    64'(bus.level),       64'd0);
        chk("reset_overflow", 64'(bus.overflow),    64'd0);
        chk("reset_frozen",   64'(bus.frozen),      64'd0);
        chk("reset_count",    64'(bus.instr_count), 64'd0);
        chk("reset_ack",      64'(bus.rd_ack),      64'd0);
        chk("reset_pc",       64'(bus.rd_pc),       64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic capture and drain
        for (int i = 0; i < 3; i++) retire(32'h100 + 32'(4 * i), 1'b0, 1'b0);
        chk("basic_level3", 64'(bus.level), 64'd3);
        for (int i = 0; i < 3; i++) pop(32'h100 + 32'(4 * i), 3'b001);
        chk("basic_level0",   64'(bus.level),    64'd0);
        chk("basic_overflow", 64'(bus.overflow), 64'd0);

        // Wrap mode overflow
        clear();
        for (int i = 0; i < 20; i++) retire(32'(4 * i), 1'b0, 1'b0);
        chk("wrap_level",    64'(bus.level),       64'd16);
        chk("wrap_overflow", 64'(bus.overflow),    64'd1);
        chk("wrap_count",    64'(bus.instr_count), 64'd20);
        for (int i = 4; i < 20; i++) pop(32'(4 * i), 3'b001);
        chk("wrap_drained", 64'(bus.level), 64'd0);
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        chk("empty_ack",  64'(bus.rd_ack), 64'd0);
        chk("empty_hold", 64'(bus.rd_pc),  64'h4C);

        // Stop-when-full
        clear();
        chk("clear_level",    64'(bus.level),       64'd0);
        chk("clear_overflow", 64'(bus.overflow),    64'd0);
        chk("clear_count",    64'(bus.instr_count), 64'd0);
        chk("clear_pc_hold",  64'(bus.rd_pc),       64'h4C);
        bus.ctl_mode = 2'd1;
        for (int i = 0; i < 20; i++) retire(32'(4 * i), 1'b0, 1'b0);
        chk("stop_level",    64'(bus.level),    64'd16);
        chk("stop_overflow", 64'(bus.overflow), 64'd1);
        for (int i = 0; i < 16; i++) pop(32'(4 * i), 3'b001);

        // Freeze on trap
        clear();
        bus.ctl_mode = 2'd2;
        for (int i = 0; i < 8; i++) retire(32'h400 + 32'(4 * i), 1'b0, i == 4);
        chk("freeze_level",  64'(bus.level),       64'd5);
        chk("freeze_frozen", 64'(bus.frozen),      64'd1);
        chk("freeze_count",  64'(bus.instr_count), 64'd8);
        for (int i = 0; i < 5; i++) pop(32'h400 + 32'(4 * i), (i == 4) ? 3'b101 : 3'b001);
        chk("freeze_sticky", 64'(bus.frozen), 64'd1);
        clear();
        chk("unfreeze_level",  64'(bus.level),       64'd0);
        chk("unfreeze_frozen", 64'(bus.frozen),      64'd0);
        chk("unfreeze_count",  64'(bus.instr_count), 64'd0);

        // Branch/trap filter
        bus.ctl_mode = 2'd3;
        for (int i = 0; i < 10; i++) retire(32'h500 + 32'(4 * i), (i == 1) || (i == 6), 1'b0);
        chk("filter_level", 64'(bus.level), 64'd2);
        pop(32'h504, 3'b011);
        pop(32'h518, 3'b011);

        // Full buffer with simultaneous capture and pop
        clear();
        bus.ctl_mode = 2'd0;
        for (int i = 0; i < 16; i++) retire(32'h200 + 32'(4 * i), 1'b0, 1'b0);
        chk("full_level", 64'(bus.level), 64'd16);
        e.pc = 32'h200;
        e.flags = 3'b001;
        q.push_back(e);
        bus.rd_req = 1'b1;
        retire(32'h300, 1'b0, 1'b0);
        bus.rd_req = 1'b0;
        chk("sim_level",    64'(bus.level),    64'd16);
        chk("sim_overflow", 64'(bus.overflow), 64'd0);
        for (int i = 1; i < 16; i++) pop(32'h200 + 32'(4 * i), 3'b001);
        pop(32'h300, 3'b001);
        retire(32'h600, 1'b0, 1'b0);

        // Clock enable low ignores trace and pop
        clk__enable = 1'b0;
        bus.rd_req  = 1'b1;
        bus.trace__instr_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("cken_ack",   64'(bus.rd_ack),      64'd0);
        chk("cken_level", 64'(bus.level),       64'd1);
        chk("cken_count", 64'(bus.instr_count), 64'd18);
        bus.trace__instr_valid = 1'b0;
        bus.rd_req  = 1'b0;
        clk__enable = 1'b1;
        @(negedge clk);

        // Async reset while a pop is being acknowledged
        bus.rd_req = 1'b1;
        @(posedge clk);
        #1;
        chk("midpop_ack", 64'(bus.rd_ack), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("areset_ack",      64'(bus.rd_ack),      64'd0);
        chk("areset_pc",       64'(bus.rd_pc),       64'd0);
        chk("areset_flags",    64'(bus.rd_flags),    64'd0);
        chk("areset_level",    64'(bus.level),       64'd0);
        chk("areset_overflow", 64'(bus.overflow),    64'd0);
        chk("areset_count",    64'(bus.instr_count), 64'd0);
        @(negedge clk);
        bus.rd_req = 1'b0;
        repeat (2) @(negedge clk);

        chk("pending_expected", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/riscv_i32_trace_buffer.md
# riscv_i32_trace_buffer

Parametrised trace capture buffer for the RISC-V i32 core. Taps the same trace bus as the simulation trace monitor, but stores retired-instruction records in an on-chip circular buffer that a debug host can read back in hardware. Adds capture filtering, freeze-on-trap, overflow tracking and a saturating instruction counter. Sits beside the CPU, clocked from the CPU clock; it never back-pressures the core.

## Interface
Parameters:
- DEPTH_LOG2, 4, buffer holds 2^DEPTH_LOG2 entries
- COUNT_WIDTH, 16, width of the retired-instruction counter

Ports:
- clk  input  1  CPU clock
- clk__enable  input  1  clock enable; no state changes when low
- reset_n  input  1  asynchronous active-low reset
- trace__instr_valid  input  1  instruction retired this cycle
- trace__instr_pc  input  32  PC of the instruction
- trace__instruction__mode  input  3  instruction mode; not stored
- trace__instruction__data  input  32  instruction word
- trace__rfw_retire  input  1  register-file write retires
- trace__rfw_data_valid  input  1  rfw data valid; not stored
- trace__rfw_rd  input  5  destination register
- trace__rfw_data  input  32  write data
- trace__branch_taken  input  1  branch taken
- trace__branch_target  input  32  branch target; not stored
- trace__trap  input  1  instruction trapped
- ctl_enable  input  1  capture and counting armed
- ctl_mode  input  2  0 wrap, 1 stop-when-full, 2 freeze-on-trap, 3 branch/trap-only (wrap)
- ctl_clear  input  1  synchronous clear of buffer and status
- rd_req  input  1  pop request
- rd_ack  output  1  rd_* data valid this cycle
- rd_pc  output  32  popped PC
- rd_instr  output  32  popped instruction
- rd_rd  output  5  popped rd
- rd_data  output  32  popped rfw data
- rd_flags  output  3  popped {trap, branch_taken, rfw_retire}
- level  output  DEPTH_LOG2+1  entries held
- overflow  output  1  sticky; entry lost or overwritten
- frozen  output  1  capture halted by trap (mode 2)
- instr_count  output  COUNT_WIDTH  retired instructions while enabled

## Operation
- Capture condition (only when clk__enable is high): ctl_enable & trace__instr_valid & !frozen & filter. The filter passes every instruction in modes 0–2. In mode 3 it passes only when branch_taken | trap.
- Stored entry: pc, instruction data, rfw_rd, rfw_data, {trap, branch_taken, rfw_retire}.
- Capture when not full: write at write pointer; level+1.
- Capture when full:
  - Modes 0 and 3: overwrite the oldest entry, advance the read pointer, set overflow.
  - Mode 1: drop the entry, set overflow.
  - Mode 2: behaves as mode 0 for the overwrite.
- Mode 2: a captured entry with trap=1 is stored, then frozen is set. frozen clears only on ctl_clear or reset.
- Pop: rd_req with level>0 registers the oldest entry onto rd_*, pulses rd_ack for one cycle, and decrements level. rd_req with level==0 gives rd_ack=0 and leaves rd_* unchanged.
- Simultaneous capture and pop:
  - Not full: level unchanged.
  - Full: the pop returns the current oldest entry; the new entry is written; no overflow.
- Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2.
- instr_count increments on every ctl_enable & trace__instr_valid, regardless of filter, freeze or full. It saturates at all-ones.
- ctl_clear has priority over capture and pop in the same cycle. Next cycle: level=0, pointers=0, overflow=0, frozen=0, instr_count=0, rd_ack=0. rd_* data holds its value.
- Changing ctl_mode mid-capture takes effect the next cycle; buffer contents are kept.

## Timing
- Reset (async, any cycle including mid-pop): every output is 0 and pointers are 0. Buffer RAM contents are don't-care.
- Capture in cycle N: visible in level, overflow and frozen at N+1. A pop requested at N+1 acks at N+2 with that entry.
- rd_req at N gives rd_ack and rd_* at N+1. All outputs are registered.
- Back-to-back rd_req every cycle drains one entry per cycle.
- clk__enable low: the cycle is ignored entirely. Trace inputs are dropped and rd_req is ignored.

## Configuration
- RISCV_I32_TRACE_RFW_DATA_EN
  - Defined: rfw_data is stored per entry and returned on rd_data.
  - Undefined: no rfw_data storage is built, and rd_data is tied to 0.
  - All other behaviour is identical either way.

## Test plan
- Reset, ctl_enable=1, mode 0, retire 3 instructions (PC 0x100/0x104/0x108); pop 3 → rd_ack each next cycle, PCs in order, level 3→0, overflow=0.
- DEPTH_LOG2=4, mode 0, retire 20 instructions (PC 0x0..0x4C) → level=16, overflow=1, pops return PC 0x10..0x4C, instr_count=20.
- Mode 1, retire 20 → level=16, pops return PC 0x0..0x3C, overflow=1.
- Mode 2, trap on the 5th instruction, 3 more retire → level=5, last entry flags=3'b1xx, frozen=1, instr_count=8. Then ctl_clear → level=0, frozen=0, instr_count=0.
- Mode 3, 10 instructions with branch_taken on #2 and #7 → level=2. Full buffer with capture and rd_req in the same cycle → oldest returned, level stays 16, no overflow.
- rd_req on empty → rd_ack=0. clk__enable=0 with instr_valid=1 → no level or count change. Async reset asserted mid-pop → all outputs 0 immediately.
